// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall/flush generation, exception/interrupt/return sequencing
// and the control-register file (CR0..CR6) read/written from the MEM stage.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic        ld_hazard,
    input  logic [7:0]  irq,
    input  logic        mem_en,
    input  logic [29:0] mem_pc,
    input  logic        mem_br_flag,
    input  logic [1:0]  mem_ctrl_op,
    input  logic [2:0]  mem_exp_code,
    input  logic [4:0]  mem_dst_addr,
    input  logic [31:0] mem_out,
    input  logic [4:0]  creg_rd_addr,
    output logic [31:0] creg_rd_data,
    output logic        exe_mode,
    output logic        int_detect,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        if_flush,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        mem_flush,
    output logic [29:0] new_pc
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_WRCR = 2'd1,
        OP_EXRT = 2'd2
    } ctrl_op_t;

    typedef enum logic [4:0] {
        CR_STATUS     = 5'd0,
        CR_PRE_STATUS = 5'd1,
        CR_EPC        = 5'd2,
        CR_EXP_VECTOR = 5'd3,
        CR_CAUSE      = 5'd4,
        CR_INT_MASK   = 5'd5,
        CR_IRQ        = 5'd6
    } creg_addr_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXP,
        EV_RET,
        EV_WRCR
    } event_t;

    logic [1:0]  status;      // {int_en, mode}
    logic [1:0]  pre_status;
    logic [29:0] epc;
    logic [29:0] exp_vector;
    logic [3:0]  cause;       // {dly, code}
    logic [7:0]  int_mask;

    logic        stall;
    logic        flush;
    event_t      ev;
    logic [2:0]  exp_code;

    assign stall      = if_busy | mem_busy;
    assign if_stall   = stall | ld_hazard;
    assign id_stall   = stall;
    assign ex_stall   = stall;
    assign mem_stall  = stall;

    assign exe_mode   = status[0];
    assign int_detect = status[1] & (|(irq & ~int_mask));

    always_comb begin
        ev       = EV_NONE;
        exp_code = mem_exp_code;
        if (mem_en) begin
            if (mem_exp_code != '0) begin
                ev = EV_EXP;
            end else if (int_detect) begin
                ev       = EV_EXP;
                exp_code = 3'd1;
            end else if (mem_ctrl_op == OP_EXRT) begin
                ev = EV_RET;
            end else if (mem_ctrl_op == OP_WRCR) begin
                ev = EV_WRCR;
            end
        end
    end

    // Flushes are forced low while reset is held, including the load-use flush.
    assign flush     = ((ev == EV_EXP) || (ev == EV_RET)) && !stall && !reset;
    assign if_flush  = flush;
    assign id_flush  = (flush | ld_hazard) & ~reset;
    assign ex_flush  = flush;
    assign mem_flush = flush;

    always_comb begin
        case (ev)
            EV_EXP:  new_pc = exp_vector;
            EV_RET:  new_pc = epc;
            default: new_pc = '0;
        endcase
    end

    always_comb begin
        case (creg_rd_addr)
            CR_STATUS:     creg_rd_data = {30'd0, status};
            CR_PRE_STATUS: creg_rd_data = {30'd0, pre_status};
            CR_EPC:        creg_rd_data = {epc, 2'b00};
            CR_EXP_VECTOR: creg_rd_data = {exp_vector, 2'b00};
            CR_CAUSE:      creg_rd_data = {28'd0, cause};
            CR_INT_MASK:   creg_rd_data = {24'd0, int_mask};
            CR_IRQ:        creg_rd_data = {24'd0, irq};
            default:       creg_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status     <= '0;
            pre_status <= '0;
            epc        <= '0;
            exp_vector <= '0;
            cause      <= '0;
            int_mask   <= '1;
        end else if (!stall) begin
            case (ev)
                EV_EXP: begin
                    pre_status <= status;
                    status     <= 2'b00;
                    epc        <= mem_pc;
                    cause      <= {mem_br_flag, exp_code};
                end
                EV_RET: begin
                    status <= pre_status;
                end
                EV_WRCR: begin
                    case (mem_dst_addr)
                        CR_STATUS:     status     <= mem_out[1:0];
                        CR_PRE_STATUS: pre_status <= mem_out[1:0];
                        CR_EPC:        epc        <= mem_out[31:2];
                        CR_EXP_VECTOR: exp_vector <= mem_out[31:2];
                        CR_CAUSE:      cause      <= mem_out[3:0];
                        CR_INT_MASK:   int_mask   <= mem_out[7:0];
                        default:       ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table-driven per-cycle vectors plus
// hand-written stall-hold and reset-during-exception sequences.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_busy, mem_busy, ld_hazard;
    logic [7:0]  irq;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [2:0]  mem_exp_code;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_out;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        exe_mode, int_detect;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0] new_pc;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
        .ld_hazard(ld_hazard), .irq(irq), .mem_en(mem_en), .mem_pc(mem_pc),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_exp_code(mem_exp_code), .mem_dst_addr(mem_dst_addr),
        .mem_out(mem_out), .creg_rd_addr(creg_rd_addr),
        .creg_rd_data(creg_rd_data), .exe_mode(exe_mode), .int_detect(int_detect),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
        .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc)
    );

    typedef struct {
        logic        ifb, memb, ldh;
        logic [7:0]  irq;
        logic        en;
        logic [29:0] pc;
        logic        br;
        logic [1:0]  op;
        logic [2:0]  code;
        logic [4:0]  dst;
        logic [31:0] dout;
        logic [4:0]  rda;
        logic [31:0] e_rd;
        logic        e_mode, e_intd;
        logic [3:0]  e_stall;   // {if, id, ex, mem}
        logic [3:0]  e_flush;   // {if, id, ex, mem}
        logic [29:0] e_npc;
    } vec_t;

    function automatic vec_t mk(
        input logic ifb, input logic memb, input logic ldh, input logic [7:0] irq_v,
        input logic en, input logic [29:0] pc, input logic br, input logic [1:0] op,
        input logic [2:0] code, input logic [4:0] dst, input logic [31:0] dout,
        input logic [4:0] rda, input logic [31:0] e_rd, input logic e_mode,
        input logic e_intd, input logic [3:0] e_stall, input logic [3:0] e_flush,
        input logic [29:0] e_npc);
        vec_t v;
        v.ifb = ifb; v.memb = memb; v.ldh = ldh; v.irq = irq_v; v.en = en;
        v.pc = pc; v.br = br; v.op = op; v.code = code; v.dst = dst;
        v.dout = dout; v.rda = rda; v.e_rd = e_rd; v.e_mode = e_mode;
        v.e_intd = e_intd; v.e_stall = e_stall; v.e_flush = e_flush; v.e_npc = e_npc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        if_busy = v.ifb; mem_busy = v.memb; ld_hazard = v.ldh; irq = v.irq;
        mem_en = v.en; mem_pc = v.pc; mem_br_flag = v.br; mem_ctrl_op = v.op;
        mem_exp_code = v.code; mem_dst_addr = v.dst; mem_out = v.dout;
        creg_rd_addr = v.rda;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " rd_data"}, creg_rd_data, v.e_rd);
        chk({tag, " exe_mode"}, {31'd0, exe_mode}, {31'd0, v.e_mode});
        chk({tag, " int_detect"}, {31'd0, int_detect}, {31'd0, v.e_intd});
        chk({tag, " stalls"}, {28'd0, if_stall, id_stall, ex_stall, mem_stall}, {28'd0, v.e_stall});
        chk({tag, " flushes"}, {28'd0, if_flush, id_flush, ex_flush, mem_flush}, {28'd0, v.e_flush});
        chk({tag, " new_pc"}, {2'b00, new_pc}, {2'b00, v.e_npc});
    endtask

    vec_t vecs[23];
    vec_t idle;

    initial begin
        //            ifb mb ld irq   en pc      br op code dst dout          rda   e_rd          md id stall    flush    npc
        vecs[0]  = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        5, 32'h000000FF, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[1]  = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[2]  = mk(0, 0, 0, 8'h00, 1, 30'h0,  0, 1, 0, 3, 32'h00001000, 3, 32'h0,        0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[3]  = mk(0, 0, 0, 8'h00, 1, 30'h40, 0, 0, 5, 0, 32'h0,        3, 32'h00001000, 0, 0, 4'b0000, 4'b1111, 30'h400);
        vecs[4]  = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        2, 32'h00000100, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[5]  = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        4, 32'h00000005, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[6]  = mk(0, 0, 0, 8'h00, 1, 30'h0,  0, 1, 0, 5, 32'h000000FE, 5, 32'h000000FF, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[7]  = mk(0, 0, 0, 8'h00, 1, 30'h0,  0, 1, 0, 0, 32'h00000003, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[8]  = mk(0, 0, 0, 8'h01, 0, 30'h0,  0, 0, 0, 0, 32'h0,        0, 32'h00000003, 1, 1, 4'b0000, 4'b0000, 30'h0);
        vecs[9]  = mk(0, 0, 0, 8'h01, 1, 30'h80, 1, 0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 4'b0000, 4'b1111, 30'h400);
        vecs[10] = mk(0, 0, 0, 8'h01, 0, 30'h0,  0, 0, 0, 0, 32'h0,        1, 32'h00000003, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[11] = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        4, 32'h00000009, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[12] = mk(0, 0, 0, 8'h00, 1, 30'h0,  0, 2, 0, 0, 32'h0,        2, 32'h00000200, 0, 0, 4'b0000, 4'b1111, 30'h80);
        vecs[13] = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        0, 32'h00000003, 1, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[14] = mk(0, 0, 1, 8'h5A, 0, 30'h0,  0, 0, 0, 0, 32'h0,        6, 32'h0000005A, 1, 0, 4'b1000, 4'b0100, 30'h0);
        vecs[15] = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 2, 0, 32'h0,        4, 32'h00000009, 1, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[16] = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        4, 32'h00000009, 1, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[17] = mk(0, 0, 0, 8'h00, 1, 30'h0,  0, 1, 0, 7, 32'hFFFFFFFF, 7, 32'h0,        1, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[18] = mk(0, 0, 0, 8'h01, 1, 30'h10, 0, 1, 0, 0, 32'h0,        0, 32'h00000003, 1, 1, 4'b0000, 4'b1111, 30'h400);
        vecs[19] = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        1, 32'h00000003, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[20] = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        4, 32'h00000001, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[21] = mk(0, 0, 0, 8'h00, 1, 30'h0,  0, 1, 0, 4, 32'hFFFFFFF6, 4, 32'h00000001, 0, 0, 4'b0000, 4'b0000, 30'h0);
        vecs[22] = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        4, 32'h00000006, 0, 0, 4'b0000, 4'b0000, 30'h0);
        idle     = mk(0, 0, 0, 8'h00, 0, 30'h0,  0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 4'b0000, 4'b0000, 30'h0);

        reset = 1'b1;
        drive(idle);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check_outs($sformatf("vec%0d", i), vecs[i]);
        end

        // State here: STATUS=0, PRE=3, EPC=0x10, VEC=0x400, CAUSE=6, MASK=FE.
        // Exception held by mem_busy for three cycles, taken on the fourth.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(idle);
            mem_busy = 1'b1; mem_en = 1'b1; mem_exp_code = 3'd3; mem_pc = 30'h33;
            creg_rd_addr = 5'd2;
            #2;
            chk($sformatf("hold%0d flushes", c), {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'h0);
            chk($sformatf("hold%0d stalls", c), {28'd0, if_stall, id_stall, ex_stall, mem_stall}, 32'hF);
            chk($sformatf("hold%0d epc", c), creg_rd_data, 32'h00000040);
        end
        @(negedge clk);
        mem_busy = 1'b0;
        creg_rd_addr = 5'd4;
        #2;
        chk("hold_release flushes", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'hF);
        chk("hold_release cause", creg_rd_data, 32'h00000006);
        chk("hold_release new_pc", {2'b00, new_pc}, 32'h00000400);
        @(negedge clk);
        drive(idle);
        creg_rd_addr = 5'd2;
        #2;
        chk("after_hold epc", creg_rd_data, 32'h000000CC);
        creg_rd_addr = 5'd4;
        #1;
        chk("after_hold cause", creg_rd_data, 32'h00000003);
        if_busy = 1'b1;
        #1;
        chk("if_busy stalls", {28'd0, if_stall, id_stall, ex_stall, mem_stall}, 32'hF);
        chk("if_busy flushes", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'h0);

        // Reset asserted in the middle of a cycle carrying an exception.
        @(negedge clk);
        drive(idle);
        mem_en = 1'b1; mem_exp_code = 3'd4; mem_pc = 30'h77; creg_rd_addr = 5'd5;
        #2;
        chk("pre_reset flushes", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'hF);
        reset = 1'b1;
        mem_busy = 1'b1;
        #1;
        chk("in_reset flushes", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'h0);
        chk("in_reset stalls", {28'd0, if_stall, id_stall, ex_stall, mem_stall}, 32'hF);
        chk("in_reset mask", creg_rd_data, 32'h000000FF);
        mem_busy = 1'b0;
        #1;
        chk("in_reset flushes nobusy", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(idle);
        creg_rd_addr = 5'd2;
        #2;
        chk("post_reset epc", creg_rd_data, 32'h0);
        creg_rd_addr = 5'd4;
        #1;
        chk("post_reset cause", creg_rd_data, 32'h0);
        creg_rd_addr = 5'd3;
        #1;
        chk("post_reset vector", creg_rd_data, 32'h0);
        creg_rd_addr = 5'd1;
        #1;
        chk("post_reset pre_status", creg_rd_data, 32'h0);
        creg_rd_addr = 5'd5;
        #1;
        chk("post_reset mask", creg_rd_data, 32'h000000FF);
        chk("post_reset exe_mode", {31'd0, exe_mode}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
